// File: rtl/cache_tag_ctrl.sv
// cache_tag_ctrl
// Direct-mapped cache lookup/refill controller. It accepts one CPU request at
// a time and sorts it into a hit, a cold miss or a conflict miss. A conflict
// miss first evicts the resident line. Every miss then refills the line from
// memory and writes the new tag into the tag store.
//
// Ports
//   clk, rst                 clock and asynchronous active-high reset
//   req_valid_i/req_addr_i   CPU request; accepted when req_ready_o is high
//   req_ready_o              high only while idle
//   done_o, hit_o            one-cycle completion pulse; hit_o qualifies it
//   index_o, tag_o           tag store address and tag (captured request)
//   we_o, deload_o           tag store write / invalidate strobes
//   tag_i, free_i            combinational tag store read data at index_o
//   mem_req_o/mem_addr_o     line refill request, held until mem_ack_i
//   mem_ack_i, mem_beat_i    refill accept and data beat strobes
//   evict_o                  one-cycle pulse when a valid line is evicted
//   hit_count_o/miss_count_o saturating statistics counters
module cache_tag_ctrl #(
    parameter int ADDR_WIDTH    = 32,
    parameter int INDEX_LENGTH  = 4,
    parameter int TAG_LENGTH    = 22,
    parameter int OFFSET_LENGTH = 6,
    parameter int REFILL_BEATS  = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    output logic                    req_ready_o,
    output logic                    done_o,
    output logic                    hit_o,
    output logic [INDEX_LENGTH-1:0] index_o,
    output logic [TAG_LENGTH-1:0]   tag_o,
    output logic                    we_o,
    output logic                    deload_o,
    input  logic [TAG_LENGTH-1:0]   tag_i,
    input  logic                    free_i,
    output logic                    mem_req_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    input  logic                    mem_ack_i,
    input  logic                    mem_beat_i,
    output logic                    evict_o,
    output logic [CNT_WIDTH-1:0]    hit_count_o,
    output logic [CNT_WIDTH-1:0]    miss_count_o
);

    // Wide enough to hold the value REFILL_BEATS itself.
    localparam int BEAT_WIDTH = $clog2(REFILL_BEATS + 1);
    localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(REFILL_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_EVICT,
        S_REFILL_REQ,
        S_REFILL,
        S_ALLOC,
        S_DONE
    } state_t;

    state_t                  state_reg, state_next;
    logic [TAG_LENGTH-1:0]   tag_reg;
    logic [INDEX_LENGTH-1:0] index_reg;
    logic                    hit_reg;
    logic [BEAT_WIDTH-1:0]   beat_cnt_reg;
    logic [CNT_WIDTH-1:0]    hit_count_reg;
    logic [CNT_WIDTH-1:0]    miss_count_reg;

    logic lookup_hit;
    logic last_beat;
    // The byte offset plays no part in line lookup.
    logic offset_unused;

    assign offset_unused = ^req_addr_i[OFFSET_LENGTH-1:0];
    assign lookup_hit    = !free_i && (tag_i == tag_reg);
    assign last_beat     = mem_beat_i && (beat_cnt_reg == LAST_BEAT);

    assign index_o      = index_reg;
    assign tag_o        = tag_reg;
    assign mem_addr_o   = {tag_reg, index_reg, {OFFSET_LENGTH{1'b0}}};
    assign hit_count_o  = hit_count_reg;
    assign miss_count_o = miss_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            tag_reg        <= '0;
            index_reg      <= '0;
            hit_reg        <= 1'b0;
            beat_cnt_reg   <= '0;
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (req_valid_i) begin
                        tag_reg   <= req_addr_i[ADDR_WIDTH-1 -: TAG_LENGTH];
                        index_reg <= req_addr_i[OFFSET_LENGTH +: INDEX_LENGTH];
                    end
                end
                S_LOOKUP:     hit_reg <= lookup_hit;
                S_REFILL_REQ: if (mem_ack_i) beat_cnt_reg <= '0;
                S_REFILL:     if (mem_beat_i) beat_cnt_reg <= beat_cnt_reg + 1'b1;
                S_DONE: begin
                    if (hit_reg) begin
                        if (hit_count_reg != '1) hit_count_reg <= hit_count_reg + 1'b1;
                    end else begin
                        if (miss_count_reg != '1) miss_count_reg <= miss_count_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next  = state_reg;
        req_ready_o = 1'b0;
        done_o      = 1'b0;
        hit_o       = 1'b0;
        we_o        = 1'b0;
        deload_o    = 1'b0;
        evict_o     = 1'b0;
        mem_req_o   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (lookup_hit)  state_next = S_DONE;
                else if (free_i) state_next = S_REFILL_REQ;
                else             state_next = S_EVICT;
            end
            S_EVICT: begin
                deload_o   = 1'b1;
                evict_o    = 1'b1;
                state_next = S_REFILL_REQ;
            end
            S_REFILL_REQ: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) state_next = S_REFILL;
            end
            S_REFILL: begin
                if (last_beat) state_next = S_ALLOC;
            end
            S_ALLOC: begin
                we_o       = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done_o     = 1'b1;
                hit_o      = hit_reg;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// tb_cache_tag_ctrl
// Drives cache_tag_ctrl with directed and randomised requests. A behavioural
// tag store answers lookups. A simple memory responder supplies the ack and
// the refill beats. Expected results come from a line-level model of a
// direct-mapped cache. A second instance with 2-bit counters shares all
// inputs and is used to check counter saturation.
module tb_cache_tag_ctrl;

    localparam int AW = 32;
    localparam int IW = 4;
    localparam int TW = 22;
    localparam int B  = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid_i = 1'b0;
    logic [AW-1:0] req_addr_i = '0;
    logic          mem_ack_i = 1'b0;
    logic          mem_beat_i = 1'b0;
    logic [TW-1:0] tag_i;
    logic          free_i;

    logic          req_ready_o, done_o, hit_o, we_o, deload_o, mem_req_o, evict_o;
    logic [IW-1:0] index_o;
    logic [TW-1:0] tag_o;
    logic [AW-1:0] mem_addr_o;
    logic [CW-1:0] hit_count_o, miss_count_o;

    logic          s_req_ready, s_done, s_hit, s_we, s_deload, s_mem_req, s_evict;
    logic [IW-1:0] s_index;
    logic [TW-1:0] s_tag;
    logic [AW-1:0] s_mem_addr;
    logic [1:0]    s_hit_count, s_miss_count;

    always #5 clk = ~clk;

    cache_tag_ctrl dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
        .req_ready_o(req_ready_o), .done_o(done_o), .hit_o(hit_o),
        .index_o(index_o), .tag_o(tag_o), .we_o(we_o), .deload_o(deload_o),
        .tag_i(tag_i), .free_i(free_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_beat_i(mem_beat_i), .evict_o(evict_o),
        .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
    );

    cache_tag_ctrl #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
        .req_ready_o(s_req_ready), .done_o(s_done), .hit_o(s_hit),
        .index_o(s_index), .tag_o(s_tag), .we_o(s_we), .deload_o(s_deload),
        .tag_i(tag_i), .free_i(free_i), .mem_req_o(s_mem_req), .mem_addr_o(s_mem_addr),
        .mem_ack_i(mem_ack_i), .mem_beat_i(mem_beat_i), .evict_o(s_evict),
        .hit_count_o(s_hit_count), .miss_count_o(s_miss_count)
    );

    // Behavioural tag store, read combinationally at the controller's index.
    logic [TW-1:0] store_tag   [16];
    logic          store_valid [16];
    assign tag_i  = store_tag[index_o];
    assign free_i = !store_valid[index_o];

    // Line-level reference model.
    logic [TW-1:0] m_tag   [16];
    logic          m_valid [16];
    int            m_hits, m_misses;

    int checks = 0;
    int failures = 0;

    // Observations of one transaction.
    int            obs_done_idx, obs_we_cnt, obs_deload_cnt, obs_evict_cnt, obs_req_cycles;
    int            obs_bad_addr, obs_bad_stable, obs_bad_ready, obs_overlap, obs_gaps;
    logic          obs_hit, obs_ready_issue;
    logic [TW-1:0] obs_we_tag;
    logic [IW-1:0] obs_we_index, obs_deload_index;
    logic [AW-1:0] obs_mem_addr;

    // 0 = hit, 1 = cold miss, 2 = conflict miss; updates the model.
    function automatic int model_step(input logic [AW-1:0] a);
        logic [TW-1:0] t;
        logic [IW-1:0] ix;
        int            cls;
        t  = a[AW-1 -: TW];
        ix = a[6 +: IW];
        if (m_valid[ix] && m_tag[ix] == t) cls = 0;
        else if (!m_valid[ix])             cls = 1;
        else                               cls = 2;
        if (cls == 0) m_hits++;
        else begin
            m_misses++;
            m_valid[ix] = 1'b1;
            m_tag[ix]   = t;
        end
        return cls;
    endfunction

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic reset_dut();
        rst = 1'b1;
        req_valid_i = 1'b0; req_addr_i = '0; mem_ack_i = 1'b0; mem_beat_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            store_valid[i] = 1'b0; store_tag[i] = '0;
            m_valid[i] = 1'b0; m_tag[i] = '0;
        end
        m_hits = 0; m_misses = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Issues one request and plays the tag store and memory until done_o.
    task automatic run_req(input logic [AW-1:0] addr, input int ack_delay,
                           input int max_gap, input bit poke);
        logic [TW-1:0] t;
        logic [IW-1:0] ix;
        logic [AW-1:0] line;
        int req_seen, phase, beats, gap;
        t = addr[AW-1 -: TW]; ix = addr[6 +: IW]; line = {t, ix, 6'b0};
        obs_done_idx = -1; obs_we_cnt = 0; obs_deload_cnt = 0; obs_evict_cnt = 0;
        obs_req_cycles = 0; obs_bad_addr = 0; obs_bad_stable = 0; obs_bad_ready = 0;
        obs_overlap = 0; obs_gaps = 0; obs_hit = 1'b0; obs_we_tag = '0;
        obs_we_index = '0; obs_deload_index = '0; obs_mem_addr = '0;
        @(negedge clk);
        obs_ready_issue = req_ready_o;
        req_valid_i = 1'b1; req_addr_i = addr;
        @(negedge clk);
        req_valid_i = 1'b0; req_addr_i = 32'h0000_3000;
        req_seen = 0; phase = 0; beats = 0; gap = $urandom_range(0, max_gap);
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (req_ready_o) obs_bad_ready++;
            if (index_o !== ix || tag_o !== t) obs_bad_stable++;
            if (we_o && deload_o) obs_overlap++;
            if (we_o) begin
                obs_we_cnt++; obs_we_tag = tag_o; obs_we_index = index_o;
                store_valid[index_o] = 1'b1; store_tag[index_o] = tag_o;
            end
            if (deload_o) begin
                obs_deload_cnt++; obs_deload_index = index_o;
                store_valid[index_o] = 1'b0;
            end
            if (evict_o) obs_evict_cnt++;
            if (mem_req_o) begin
                if (obs_req_cycles == 0) obs_mem_addr = mem_addr_o;
                obs_req_cycles++;
                if (mem_addr_o !== line) obs_bad_addr++;
            end
            if (done_o) begin
                obs_done_idx = cyc; obs_hit = hit_o;
            end
            mem_ack_i  = 1'b0;
            mem_beat_i = 1'($urandom_range(0, 1));  // spurious beats must be ignored
            if (phase == 0 && mem_req_o) begin
                if (req_seen == ack_delay) begin
                    mem_ack_i = 1'b1; phase = 1;
                end
                req_seen++;
            end else if (phase == 1) begin
                if (gap > 0) begin
                    mem_beat_i = 1'b0; gap--; obs_gaps++;
                end else begin
                    mem_beat_i = 1'b1; beats++; gap = $urandom_range(0, max_gap);
                    if (beats == B) phase = 2;
                end
            end
            req_valid_i = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            if (done_o) begin
                req_valid_i = 1'b0; mem_beat_i = 1'b0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        mem_ack_i = 1'b0; mem_beat_i = 1'b0;
        $display("txn addr=%08h done_cyc=%0d hit=%0b mem_req_cycles=%0d evict=%0d we=%0d hits=%0d misses=%0d",
                 addr, obs_done_idx, obs_hit, obs_req_cycles, obs_evict_cnt, obs_we_cnt,
                 hit_count_o, miss_count_o);
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if ({req_ready_o, done_o, hit_o, we_o, deload_o, mem_req_o, evict_o} !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 1000000",
                     {req_ready_o, done_o, hit_o, we_o, deload_o, mem_req_o, evict_o});
        end
        checks++;
        if (index_o !== '0 || tag_o !== '0 || mem_addr_o !== '0) begin
            failures++;
            $display("FAIL reset_addr: got idx=%0h tag=%0h mem=%0h expected 0", index_o, tag_o, mem_addr_o);
        end
        checks++;
        if (hit_count_o !== '0 || miss_count_o !== '0) begin
            failures++;
            $display("FAIL reset_counts: got %0d/%0d expected 0/0", hit_count_o, miss_count_o);
        end
    endtask

    task automatic test_cold_miss();
        int cls;
        cls = model_step(32'h0000_1040);
        run_req(32'h0000_1040, 1, 0, 1'b0);
        checks++;
        if (obs_mem_addr !== 32'h0000_1040 || obs_bad_addr != 0) begin
            failures++;
            $display("FAIL cold_mem_addr: got %08h (bad=%0d) expected 00001040", obs_mem_addr, obs_bad_addr);
        end
        checks++;
        if (obs_we_cnt != 1 || obs_we_index !== 4'd1 || obs_we_tag !== 22'h4) begin
            failures++;
            $display("FAIL cold_we: got cnt=%0d idx=%0h tag=%0h expected 1/1/4", obs_we_cnt, obs_we_index, obs_we_tag);
        end
        checks++;
        // LOOKUP, REFILL_REQ x2 (ack after one cycle), REFILL x4, ALLOC, then DONE
        if (obs_done_idx != 8 || obs_hit !== 1'b0 || cls != 1) begin
            failures++;
            $display("FAIL cold_done: got cyc=%0d hit=%0b expected 8/0", obs_done_idx, obs_hit);
        end
        checks++;
        if (miss_count_o !== 16'd1 || hit_count_o !== 16'd0) begin
            failures++;
            $display("FAIL cold_counts: got %0d/%0d expected 0/1", hit_count_o, miss_count_o);
        end
    endtask

    task automatic test_hit();
        int cls;
        cls = model_step(32'h0000_107C);
        run_req(32'h0000_107C, 0, 0, 1'b0);
        checks++;
        // accept cycle, LOOKUP, DONE
        if (obs_done_idx != 1 || obs_hit !== 1'b1 || cls != 0) begin
            failures++;
            $display("FAIL hit_done: got cyc=%0d hit=%0b expected 1/1", obs_done_idx, obs_hit);
        end
        checks++;
        if (obs_req_cycles != 0 || obs_we_cnt != 0 || obs_deload_cnt != 0) begin
            failures++;
            $display("FAIL hit_quiet: got req=%0d we=%0d deload=%0d expected 0", obs_req_cycles, obs_we_cnt, obs_deload_cnt);
        end
        checks++;
        if (hit_count_o !== 16'd1) begin
            failures++;
            $display("FAIL hit_count: got %0d expected 1", hit_count_o);
        end
    endtask

    task automatic test_conflict();
        int cls;
        cls = model_step(32'h0000_2040);
        run_req(32'h0000_2040, 0, 0, 1'b0);
        checks++;
        if (obs_deload_cnt != 1 || obs_evict_cnt != 1 || obs_deload_index !== 4'd1 || cls != 2) begin
            failures++;
            $display("FAIL conflict_evict: got deload=%0d evict=%0d idx=%0h expected 1/1/1",
                     obs_deload_cnt, obs_evict_cnt, obs_deload_index);
        end
        checks++;
        if (obs_mem_addr !== 32'h0000_2040 || obs_we_tag !== 22'h8 || obs_we_cnt != 1) begin
            failures++;
            $display("FAIL conflict_refill: got mem=%08h tag=%0h we=%0d expected 00002040/8/1",
                     obs_mem_addr, obs_we_tag, obs_we_cnt);
        end
        checks++;
        if (obs_overlap != 0 || obs_done_idx != 8) begin
            failures++;
            $display("FAIL conflict_done: got overlap=%0d cyc=%0d expected 0/8", obs_overlap, obs_done_idx);
        end
    endtask

    task automatic test_stall_busy();
        int cls;
        cls = model_step(32'h0000_1080);
        run_req(32'h0000_1080, 10, 0, 1'b1);
        checks++;
        if (obs_req_cycles != 11 || obs_bad_addr != 0) begin
            failures++;
            $display("FAIL stall_req: got cycles=%0d bad_addr=%0d expected 11/0", obs_req_cycles, obs_bad_addr);
        end
        checks++;
        if (obs_bad_ready != 0 || obs_bad_stable != 0 || cls != 1) begin
            failures++;
            $display("FAIL stall_busy: got ready_high=%0d unstable=%0d expected 0/0", obs_bad_ready, obs_bad_stable);
        end
        checks++;
        if (obs_done_idx != 17) begin
            failures++;
            $display("FAIL stall_done: got cyc=%0d expected 17", obs_done_idx);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready_o !== 1'b1 || done_o !== 1'b0 || tag_o !== 22'h4 || index_o !== 4'd2) begin
            failures++;
            $display("FAIL stall_nocapture: got ready=%0b done=%0b tag=%0h idx=%0h expected 1/0/4/2",
                     req_ready_o, done_o, tag_o, index_o);
        end
    endtask

    task automatic test_reset_mid_refill();
        int saw_we;
        int cls;
        reset_dut();
        @(negedge clk); req_valid_i = 1'b1; req_addr_i = 32'h0000_1040;
        @(negedge clk); req_valid_i = 1'b0;
        @(negedge clk); mem_ack_i = 1'b1;
        @(negedge clk); mem_ack_i = 1'b0; mem_beat_i = 1'b1;
        @(negedge clk); mem_beat_i = 1'b1;
        @(negedge clk); mem_beat_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (req_ready_o !== 1'b1 || index_o !== '0 || tag_o !== '0 || we_o !== 1'b0 || mem_req_o !== 1'b0) begin
            failures++;
            $display("FAIL midreset_clear: got ready=%0b idx=%0h tag=%0h we=%0b req=%0b expected 1/0/0/0/0",
                     req_ready_o, index_o, tag_o, we_o, mem_req_o);
        end
        m_hits = 0; m_misses = 0;
        @(negedge clk); rst = 1'b0;
        saw_we = 0;
        repeat (6) begin
            @(negedge clk);
            if (we_o || !req_ready_o) saw_we++;
        end
        checks++;
        if (saw_we != 0) begin
            failures++;
            $display("FAIL midreset_idle: got %0d active cycles expected 0", saw_we);
        end
        cls = model_step(32'h0000_1040);
        run_req(32'h0000_1040, 0, 0, 1'b0);
        checks++;
        if (obs_done_idx != 7 || obs_we_cnt != 1 || miss_count_o !== 16'd1 || cls != 1) begin
            failures++;
            $display("FAIL midreset_refill: got cyc=%0d we=%0d misses=%0d expected 7/1/1",
                     obs_done_idx, obs_we_cnt, miss_count_o);
        end
    endtask

    task automatic test_saturation();
        int cls;
        logic [5:0] off;
        reset_dut();
        store_valid[5] = 1'b1; store_tag[5] = 22'h7;
        m_valid[5] = 1'b1; m_tag[5] = 22'h7;
        for (int i = 0; i < 5; i++) begin
            off = 6'($urandom_range(0, 63));
            cls = model_step({22'h7, 4'd5, off});
            run_req({22'h7, 4'd5, off}, 0, 0, 1'b0);
            checks++;
            if (obs_hit !== 1'b1 || cls != 0) begin
                failures++;
                $display("FAIL sat_hit%0d: got hit=%0b expected 1", i, obs_hit);
            end
        end
        checks++;
        if (s_hit_count !== 2'd3 || s_miss_count !== 2'd0) begin
            failures++;
            $display("FAIL sat_counts: got %0d/%0d expected 3/0", s_hit_count, s_miss_count);
        end
        checks++;
        if (hit_count_o !== 16'd5) begin
            failures++;
            $display("FAIL sat_wide: got %0d expected 5", hit_count_o);
        end
    endtask

    task automatic test_random();
        logic [TW-1:0] tg;
        logic [IW-1:0] ix;
        logic [5:0]    off;
        logic [AW-1:0] a;
        int cls, ad, exp_idx;
        for (int n = 0; n < 40; n++) begin
            tg  = TW'($urandom_range(0, 3));
            ix  = IW'($urandom_range(0, 15));
            off = 6'($urandom_range(0, 63));
            a   = {tg, ix, off};
            cls = model_step(a);
            ad  = $urandom_range(0, 3);
            run_req(a, ad, 2, 1'($urandom_range(0, 1)));
            exp_idx = (cls == 0) ? 1 : 3 + ((cls == 2) ? 1 : 0) + ad + B + obs_gaps;
            checks++;
            if (obs_hit !== (cls == 0) || obs_done_idx != exp_idx || obs_ready_issue !== 1'b1) begin
                failures++;
                $display("FAIL rand_done: addr=%08h got hit=%0b cyc=%0d expected hit=%0b cyc=%0d",
                         a, obs_hit, obs_done_idx, (cls == 0), exp_idx);
            end
            checks++;
            if (obs_we_cnt != ((cls == 0) ? 0 : 1) || obs_deload_cnt != ((cls == 2) ? 1 : 0) ||
                obs_evict_cnt != ((cls == 2) ? 1 : 0) || obs_req_cycles != ((cls == 0) ? 0 : ad + 1)) begin
                failures++;
                $display("FAIL rand_strobes: addr=%08h got we=%0d deload=%0d evict=%0d req=%0d class=%0d",
                         a, obs_we_cnt, obs_deload_cnt, obs_evict_cnt, obs_req_cycles, cls);
            end
            checks++;
            if (obs_bad_addr != 0 || obs_bad_stable != 0 || obs_bad_ready != 0 || obs_overlap != 0 ||
                (cls != 0 && obs_we_tag !== tg)) begin
                failures++;
                $display("FAIL rand_protocol: addr=%08h got bad_addr=%0d unstable=%0d ready=%0d overlap=%0d we_tag=%0h",
                         a, obs_bad_addr, obs_bad_stable, obs_bad_ready, obs_overlap, obs_we_tag);
            end
            checks++;
            if (hit_count_o !== CW'(m_hits) || miss_count_o !== CW'(m_misses) ||
                s_hit_count !== 2'(sat3(m_hits)) || s_miss_count !== 2'(sat3(m_misses))) begin
                failures++;
                $display("FAIL rand_counts: got %0d/%0d sat %0d/%0d expected %0d/%0d sat %0d/%0d",
                         hit_count_o, miss_count_o, s_hit_count, s_miss_count,
                         m_hits, m_misses, sat3(m_hits), sat3(m_misses));
            end
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_stall_busy();
        test_reset_mid_refill();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
